counter_stream_checker: RTL and testbench



---
 rtl/counter_stream_checker.sv | 139 +++++++++++++
 tb/tb_counter_stream_checker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_stream_checker.sv
// counter_stream_checker
// Receive-side checker for a free-running counter bus. Each accepted sample
// must equal the previous sample plus STEP (mod 2^WIDTH). After LOCK_COUNT
// consecutive good samples the checker locks; once locked it flags mismatches
// and wraps, and keeps a saturating error count.
//
// Ports
//   clk        clock, all state changes on rising edge
//   rst_n      synchronous active-low reset
//   ena        design enable; low freezes all state except clear_err
//   sample_en  sample strobe, qualified by ena
//   count_in   counter value under check
//   clear_err  synchronous clear of err_cnt (wins over a coincident increment)
//   locked     high while in LOCKED
//   mismatch   one-cycle pulse: sample accepted in LOCKED did not match
//   wrap       one-cycle pulse: good sample in LOCKED whose +STEP carries out
//   err_cnt    saturating mismatch count
//   expected   next expected value
//
// state   | meaning
// IDLE    | no reference yet; first accepted sample seeds expected
// ACQUIRE | counting consecutive good samples toward LOCK_COUNT
// LOCKED  | tracking; mismatches counted and drop back to ACQUIRE
module counter_stream_checker #(
  parameter int WIDTH      = 4,
  parameter int STEP       = 1,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             mismatch,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [3:0]     LOCK_RUN = 4'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             mismatch_q, mismatch_d;
  logic             wrap_q, wrap_d;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             match;

  assign accept = ena & sample_en;
  assign sum    = {1'b0, count_in} + STEP_EXT;
  assign carry  = sum[WIDTH];
  assign match  = (count_in == exp_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_q      <= '0;
      exp_q      <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      wrap_q     <= wrap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    exp_d      = exp_q;
    err_d      = err_q;
    mismatch_d = 1'b0;
    wrap_d     = 1'b0;

    if (accept) begin
      case (state_q)
        IDLE: begin
          exp_d   = sum[WIDTH-1:0];
          run_d   = 4'd1;
          state_d = ACQUIRE;
        end
        ACQUIRE: begin
          exp_d = sum[WIDTH-1:0];
          if (match) begin
            run_d = run_q + 4'd1;
            if (run_q + 4'd1 == LOCK_RUN) state_d = LOCKED;
          end else begin
            // resync silently: acquisition errors are not counted
            run_d = 4'd1;
          end
        end
        LOCKED: begin
          exp_d = sum[WIDTH-1:0];
          if (match) begin
            wrap_d = carry;
          end else begin
            mismatch_d = 1'b1;
            if (err_q != '1) err_d = err_q + 1'b1;
            run_d   = 4'd1;
            state_d = ACQUIRE;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end

    if (clear_err) err_d = '0;
  end

  assign locked   = (state_q == LOCKED);
  assign mismatch = mismatch_q;
  assign wrap     = wrap_q;
  assign err_cnt  = err_q;
  assign expected = exp_q;

endmodule

// File: tb/tb_counter_stream_checker.sv
module tb_counter_stream_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       sample_en = 1'b0;
  logic [3:0] count_in = '0;
  logic       clear_err = 1'b0;
  logic       locked, mismatch, wrap;
  logic [3:0] err_cnt, expected;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_stream_checker #(.WIDTH(4), .STEP(1), .LOCK_COUNT(3), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_en(sample_en),
    .count_in(count_in), .clear_err(clear_err), .locked(locked),
    .mismatch(mismatch), .wrap(wrap), .err_cnt(err_cnt), .expected(expected)
  );

  typedef struct {
    logic       locked;
    logic       mismatch;
    logic       wrap;
    logic [3:0] err;
    logic [3:0] exp;
  } result_t;

  result_t sb[$];

  // reference model: 0=IDLE 1=ACQUIRE 2=LOCKED
  int m_st = 0, m_run = 0, m_exp = 0, m_err = 0;
  int wrap_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic model(input logic r, input logic en, input logic se, input int cin, input logic clr);
    result_t res;
    int nexp;
    res.mismatch = 1'b0;
    res.wrap     = 1'b0;
    if (!r) begin
      m_st = 0; m_run = 0; m_exp = 0; m_err = 0;
    end else begin
      if (en && se) begin
        nexp = (cin + 1) % 16;
        if (m_st == 0) begin
          m_exp = nexp; m_run = 1; m_st = 1;
        end else if (m_st == 1) begin
          if (cin == m_exp) begin
            m_run = m_run + 1;
            if (m_run == 3) m_st = 2;
          end else m_run = 1;
          m_exp = nexp;
        end else begin
          if (cin == m_exp) res.wrap = (cin == 15);
          else begin
            res.mismatch = 1'b1;
            if (m_err < 15) m_err = m_err + 1;
            m_st = 1; m_run = 1;
          end
          m_exp = nexp;
        end
      end
      if (clr) m_err = 0;
    end
    res.locked = (m_st == 2);
    res.err    = 4'(m_err);
    res.exp    = 4'(m_exp);
    sb.push_back(res);
  endtask

  task automatic step(input logic r, input logic en, input logic se, input int cin, input logic clr);
    result_t e;
    rst_n = r; ena = en; sample_en = se; count_in = 4'(cin); clear_err = clr;
    model(r, en, se, cin, clr);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("locked", 32'(locked), 32'(e.locked));
    chk("mismatch", 32'(mismatch), 32'(e.mismatch));
    chk("wrap", 32'(wrap), 32'(e.wrap));
    chk("err_cnt", 32'(err_cnt), 32'(e.err));
    chk("expected", 32'(expected), 32'(e.exp));
    if (wrap === 1'b1) wrap_seen++;
    rst_n = 1'b1; sample_en = 1'b0; clear_err = 1'b0; ena = 1'b1;
  endtask

  task automatic samp(input int cin);
    step(1'b1, 1'b1, 1'b1, cin, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1, 9, 1'b0);
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_expected", 32'(expected), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);

    // lock and wrap
    samp(0); samp(1);
    chk("prelock", 32'(locked), 32'd0);
    samp(2);
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_expected", 32'(expected), 32'd3);
    wrap_seen = 0;
    for (int v = 3; v <= 14; v++) samp(v);
    chk("no_early_wrap", 32'(wrap_seen), 32'd0);
    samp(15);
    chk("wrap_on_15", 32'(wrap), 32'd1);
    chk("wrap_expected", 32'(expected), 32'd0);
    samp(0);
    chk("wrap_once", 32'(wrap_seen), 32'd1);
    chk("wrap_err", 32'(err_cnt), 32'd0);

    // locked mismatch
    do_reset();
    samp(2); samp(3); samp(4);
    chk("lm_expected", 32'(expected), 32'd5);
    samp(9);
    chk("lm_pulse", 32'(mismatch), 32'd1);
    chk("lm_err", 32'(err_cnt), 32'd1);
    chk("lm_unlocked", 32'(locked), 32'd0);
    chk("lm_expected2", 32'(expected), 32'd10);
    samp(10);
    chk("lm_pulse_gone", 32'(mismatch), 32'd0);
    samp(11);
    chk("lm_relock", 32'(locked), 32'd1);

    // acquisition resync
    do_reset();
    samp(0); samp(1); samp(7);
    chk("rs_no_pulse", 32'(mismatch), 32'd0);
    samp(8);
    chk("rs_not_locked", 32'(locked), 32'd0);
    samp(9);
    chk("rs_locked", 32'(locked), 32'd1);
    chk("rs_err", 32'(err_cnt), 32'd0);

    // gating with ena=0, then gap with sample_en=0
    do_reset();
    samp(1); samp(2); samp(3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 12, 1'b0);
    chk("gate_expected", 32'(expected), 32'd4);
    chk("gate_locked", 32'(locked), 32'd1);
    step(1'b1, 1'b1, 1'b0, 7, 1'b0);
    samp(4);
    chk("gate_match", 32'(expected), 32'd5);
    chk("gate_no_mm", 32'(mismatch), 32'd0);

    // saturation: 20 locked mismatches with relock between
    for (int i = 0; i < 20; i++) begin
      samp((m_exp + 5) % 16);
      chk("sat_pulse", 32'(mismatch), 32'd1);
      samp(m_exp);
      samp(m_exp);
    end
    chk("sat_err", 32'(err_cnt), 32'd15);
    chk("sat_locked", 32'(locked), 32'd1);
    // clear_err coinciding with a mismatch
    step(1'b1, 1'b1, 1'b1, (m_exp + 3) % 16, 1'b1);
    chk("clr_err", 32'(err_cnt), 32'd0);
    chk("clr_pulse", 32'(mismatch), 32'd1);
    chk("clr_unlocked", 32'(locked), 32'd0);
    // clear_err honoured while ena=0
    samp(m_exp); samp(m_exp);
    samp((m_exp + 2) % 16);
    chk("err_before_gclr", 32'(err_cnt), 32'd1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    chk("gated_clr", 32'(err_cnt), 32'd0);

    // reset mid-operation
    do_reset();
    samp(4); samp(5); samp(6);
    chk("mid_pre_expected", 32'(expected), 32'd7);
    do_reset();
    chk("mid_locked", 32'(locked), 32'd0);
    chk("mid_expected", 32'(expected), 32'd0);
    samp(3);
    chk("mid_after_expected", 32'(expected), 32'd4);
    chk("mid_after_mm", 32'(mismatch), 32'd0);
    chk("mid_after_locked", 32'(locked), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
